// File: rtl/sdk_fifo_bridge.sv
// FPGA-side end of the SDK FIFO handshake: a host->harness downlink FIFO and a
// harness->host uplink FIFO with show-ahead reads. Optional sticky error flags under SDK_FIFO_ERR_EN.

module sdk_fifo_core #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [WIDTH-1:0]      i_push_data,
    input  logic                  i_pop,
    output logic [WIDTH-1:0]      o_head,
    output logic [DEPTH_LOG2:0]   o_count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2+1)'(0);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_push_ok;
    logic                  w_pop_ok;

    // Fullness uses the pre-edge count, so a same-cycle pop never frees a slot for the push.
    assign w_push_ok = i_push && (r_count < CNT_FULL);
    assign w_pop_ok  = i_pop  && (r_count != CNT_ZERO);

    assign o_head  = (r_count != CNT_ZERO) ? r_mem[r_rptr] : {WIDTH{1'b0}};
    assign o_count = r_count;

    // Storage write; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= PTR_ZERO;
            r_rptr  <= PTR_ZERO;
            r_count <= CNT_ZERO;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module sdk_fifo_bridge #(
    parameter int WIDTH        = 16,
    parameter int DEPTH_LOG2   = 4,
    parameter int AFULL_MARGIN = 4
) (
    input  logic             SDK_CLK,
    input  logic             SDK_RSTN,
    input  logic             SDK_RD,
    output logic [WIDTH-1:0] SDK_DI,
    output logic             SDK_Empty,
    output logic             SDK_AlmostEmpty,
    input  logic             SDK_WR,
    input  logic [WIDTH-1:0] SDK_DO,
    output logic             SDK_AlmostFull,
    input  logic             host_wr_en,
    input  logic [WIDTH-1:0] host_wr_data,
    output logic             host_wr_full,
    input  logic             host_rd_en,
    output logic [WIDTH-1:0] host_rd_data,
    output logic             host_rd_empty,
    output logic             err_ovf,
    output logic             err_udf
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] CNT_ZERO = (DEPTH_LOG2+1)'(0);
    localparam logic [DEPTH_LOG2:0] CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] AFULL_C  = (DEPTH_LOG2+1)'(AFULL_MARGIN);

    logic [DEPTH_LOG2:0] w_dl_count;
    logic [DEPTH_LOG2:0] w_ul_count;

    sdk_fifo_core #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_downlink (
        .clk         (SDK_CLK),
        .rst_n       (SDK_RSTN),
        .i_push      (host_wr_en),
        .i_push_data (host_wr_data),
        .i_pop       (SDK_RD),
        .o_head      (SDK_DI),
        .o_count     (w_dl_count)
    );

    sdk_fifo_core #(.WIDTH(WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_uplink (
        .clk         (SDK_CLK),
        .rst_n       (SDK_RSTN),
        .i_push      (SDK_WR),
        .i_push_data (SDK_DO),
        .i_pop       (host_rd_en),
        .o_head      (host_rd_data),
        .o_count     (w_ul_count)
    );

    // AlmostEmpty at count<=1 guarantees a harness popping while it is low sees another word.
    assign SDK_Empty       = (w_dl_count == CNT_ZERO);
    assign SDK_AlmostEmpty = (w_dl_count <= CNT_ONE);
    assign host_wr_full    = (w_dl_count == CNT_FULL);
    assign host_rd_empty   = (w_ul_count == CNT_ZERO);
    assign SDK_AlmostFull  = ((CNT_FULL - w_ul_count) <= AFULL_C);

`ifdef SDK_FIFO_ERR_EN
    logic r_err_ovf;
    logic r_err_udf;
    logic w_ovf_evt;
    logic w_udf_evt;

    assign w_ovf_evt = (host_wr_en && host_wr_full) || (SDK_WR && (w_ul_count == CNT_FULL));
    assign w_udf_evt = (SDK_RD && SDK_Empty) || (host_rd_en && host_rd_empty);

    // Sticky error capture, cleared only by reset.
    always_ff @(posedge SDK_CLK or negedge SDK_RSTN) begin
        if (!SDK_RSTN) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            r_err_ovf <= r_err_ovf | w_ovf_evt;
            r_err_udf <= r_err_udf | w_udf_evt;
        end
    end

    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;
`else
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif
endmodule

// File: tb/tb_sdk_fifo_bridge.sv
// Scoreboard bench for sdk_fifo_bridge: stimulus queues expected read data, a
// negedge monitor compares every accepted-strobe read; flags are checked directly.

module tb_sdk_fifo_bridge;
    logic        SDK_CLK = 1'b0;
    logic        SDK_RSTN = 1'b0;
    logic        SDK_RD = 1'b0;
    logic [15:0] SDK_DI;
    logic        SDK_Empty;
    logic        SDK_AlmostEmpty;
    logic        SDK_WR = 1'b0;
    logic [15:0] SDK_DO = 16'h0000;
    logic        SDK_AlmostFull;
    logic        host_wr_en = 1'b0;
    logic [15:0] host_wr_data = 16'h0000;
    logic        host_wr_full;
    logic        host_rd_en = 1'b0;
    logic [15:0] host_rd_data;
    logic        host_rd_empty;
    logic        err_ovf;
    logic        err_udf;

    int errors = 0;
    int checks = 0;
    logic [15:0] dl_q[$];
    logic [15:0] ul_q[$];
    logic        err_en;

    sdk_fifo_bridge #(.WIDTH(16), .DEPTH_LOG2(4), .AFULL_MARGIN(4)) dut (
        .SDK_CLK         (SDK_CLK),
        .SDK_RSTN        (SDK_RSTN),
        .SDK_RD          (SDK_RD),
        .SDK_DI          (SDK_DI),
        .SDK_Empty       (SDK_Empty),
        .SDK_AlmostEmpty (SDK_AlmostEmpty),
        .SDK_WR          (SDK_WR),
        .SDK_DO          (SDK_DO),
        .SDK_AlmostFull  (SDK_AlmostFull),
        .host_wr_en      (host_wr_en),
        .host_wr_data    (host_wr_data),
        .host_wr_full    (host_wr_full),
        .host_rd_en      (host_rd_en),
        .host_rd_data    (host_rd_data),
        .host_rd_empty   (host_rd_empty),
        .err_ovf         (err_ovf),
        .err_udf         (err_udf)
    );

    always #5 SDK_CLK = ~SDK_CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: reads are sampled mid-cycle, before the consuming edge.
    always @(negedge SDK_CLK) begin
        if (SDK_RSTN && SDK_RD) begin
            if (dl_q.size() != 0) chk("dl_data", {16'h0000, SDK_DI}, {16'h0000, dl_q.pop_front()});
            else                  chk("dl_empty_rd", {31'd0, SDK_Empty}, 32'd1);
        end
        if (SDK_RSTN && host_rd_en) begin
            if (ul_q.size() != 0) chk("ul_data", {16'h0000, host_rd_data}, {16'h0000, ul_q.pop_front()});
            else                  chk("ul_empty_rd", {31'd0, host_rd_empty}, 32'd1);
        end
    end

    task automatic tick();
        @(posedge SDK_CLK);
        #1;
        SDK_RD     = 1'b0;
        SDK_WR     = 1'b0;
        host_wr_en = 1'b0;
        host_rd_en = 1'b0;
    endtask

    task automatic host_push(input logic [15:0] d, input bit accept);
        host_wr_en   = 1'b1;
        host_wr_data = d;
        if (accept) dl_q.push_back(d);
    endtask

    task automatic harness_push(input logic [15:0] d);
        SDK_WR = 1'b1;
        SDK_DO = d;
        ul_q.push_back(d);
    endtask

    task automatic chk_reset_flags(input string tag);
        chk({tag, "_empty"}, {31'd0, SDK_Empty}, 32'd1);
        chk({tag, "_aempty"}, {31'd0, SDK_AlmostEmpty}, 32'd1);
        chk({tag, "_afull"}, {31'd0, SDK_AlmostFull}, 32'd0);
        chk({tag, "_wfull"}, {31'd0, host_wr_full}, 32'd0);
        chk({tag, "_rempty"}, {31'd0, host_rd_empty}, 32'd1);
        chk({tag, "_di"}, {16'h0000, SDK_DI}, 32'd0);
        chk({tag, "_rdata"}, {16'h0000, host_rd_data}, 32'd0);
        chk({tag, "_ovf"}, {31'd0, err_ovf}, 32'd0);
        chk({tag, "_udf"}, {31'd0, err_udf}, 32'd0);
    endtask

    initial begin
`ifdef SDK_FIFO_ERR_EN
        err_en = 1'b1;
`else
        err_en = 1'b0;
`endif
        repeat (3) @(posedge SDK_CLK);
        @(negedge SDK_CLK);
        SDK_RSTN = 1'b1;
        @(posedge SDK_CLK);
        #1;
        chk_reset_flags("rst");

        // Two host pushes, then one harness pop.
        host_push(16'h1111, 1'b1);
        tick();
        chk("p1_empty", {31'd0, SDK_Empty}, 32'd0);
        chk("p1_aempty", {31'd0, SDK_AlmostEmpty}, 32'd1);
        chk("p1_di", {16'h0000, SDK_DI}, 32'h1111);
        host_push(16'h2222, 1'b1);
        tick();
        chk("p2_aempty", {31'd0, SDK_AlmostEmpty}, 32'd0);
        SDK_RD = 1'b1;
        tick();
        chk("rd1_di", {16'h0000, SDK_DI}, 32'h2222);
        chk("rd1_aempty", {31'd0, SDK_AlmostEmpty}, 32'd1);
        SDK_RD = 1'b1;
        tick();
        chk("rd2_empty", {31'd0, SDK_Empty}, 32'd1);

        // Uplink AlmostFull threshold at 12 words (free = 4).
        for (int i = 0; i < 12; i++) begin
            harness_push(16'hA000 + 16'(i));
            tick();
            chk($sformatf("ul_afull_%0d", i + 1), {31'd0, SDK_AlmostFull}, (i == 11) ? 32'd1 : 32'd0);
        end
        chk("ul_rempty", {31'd0, host_rd_empty}, 32'd0);
        host_rd_en = 1'b1;
        tick();
        chk("ul_afull_fall", {31'd0, SDK_AlmostFull}, 32'd0);
        chk("ul_head", {16'h0000, host_rd_data}, 32'hA001);
        for (int i = 0; i < 11; i++) begin
            host_rd_en = 1'b1;
            tick();
        end
        chk("ul_drained", {31'd0, host_rd_empty}, 32'd1);

        // Fill downlink, overflow with DEAD, drain in order.
        for (int i = 0; i < 16; i++) begin
            host_push(16'h3000 + 16'(i), 1'b1);
            tick();
            chk($sformatf("dl_full_%0d", i + 1), {31'd0, host_wr_full}, (i == 15) ? 32'd1 : 32'd0);
        end
        host_push(16'hDEAD, 1'b0);
        tick();
        chk("ovf_full", {31'd0, host_wr_full}, 32'd1);
        chk("ovf_flag", {31'd0, err_ovf}, {31'd0, err_en});
        chk("ovf_head", {16'h0000, SDK_DI}, 32'h3000);
        for (int i = 0; i < 16; i++) begin
            SDK_RD = 1'b1;
            tick();
        end
        chk("dl_drained", {31'd0, SDK_Empty}, 32'd1);
        chk("dl_drained_di", {16'h0000, SDK_DI}, 32'd0);

        // Simultaneous push and pop with one word held.
        host_push(16'h5555, 1'b1);
        tick();
        host_push(16'h6666, 1'b1);
        SDK_RD = 1'b1;
        tick();
        chk("pp_empty", {31'd0, SDK_Empty}, 32'd0);
        chk("pp_aempty", {31'd0, SDK_AlmostEmpty}, 32'd1);
        chk("pp_di", {16'h0000, SDK_DI}, 32'h6666);
        SDK_RD = 1'b1;
        tick();
        chk("pp_drained", {31'd0, SDK_Empty}, 32'd1);

        // Underflow attempts on both FIFOs.
        chk("udf_before", {31'd0, err_udf}, 32'd0);
        SDK_RD = 1'b1;
        tick();
        chk("udf_flag", {31'd0, err_udf}, {31'd0, err_en});
        chk("udf_empty", {31'd0, SDK_Empty}, 32'd1);
        host_rd_en = 1'b1;
        tick();
        chk("udf_rempty", {31'd0, host_rd_empty}, 32'd1);
        host_push(16'h7777, 1'b1);
        tick();
        chk("udf_di", {16'h0000, SDK_DI}, 32'h7777);
        chk("udf_aempty", {31'd0, SDK_AlmostEmpty}, 32'd1);

        // Mid-stream asynchronous reset flushes both FIFOs.
        host_push(16'h8001, 1'b0);
        tick();
        harness_push(16'hB001);
        tick();
        harness_push(16'hB002);
        tick();
        #2;
        SDK_RSTN = 1'b0;
        dl_q.delete();
        ul_q.delete();
        #1;
        chk_reset_flags("mrst");
        @(negedge SDK_CLK);
        SDK_RSTN = 1'b1;
        host_push(16'h8888, 1'b1);
        tick();
        chk("post_rst_di", {16'h0000, SDK_DI}, 32'h8888);
        chk("post_rst_aempty", {31'd0, SDK_AlmostEmpty}, 32'd1);
        SDK_RD = 1'b1;
        tick();
        chk("post_rst_empty", {31'd0, SDK_Empty}, 32'd1);

        repeat (2) @(posedge SDK_CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
